// File: rtl/alu_op_sequencer.sv
// Registered initiator for the combinational ALU: accepts a request, drives the ALU
// operands for one settle cycle, then returns the latched result and status flags.
module alu_op_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_sel,
   output logic [WIDTH-1:0] alu_inputA,
   output logic [WIDTH-1:0] alu_inputB,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_neg,
   output logic             res_carry,
   output logic             res_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] SEL_ADD = 2'd0;
   localparam logic [1:0] SEL_SUB = 2'd1;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_aluA;
   logic [WIDTH-1:0] r_aluB;
   logic [1:0]       r_aluSel;
   logic [WIDTH-1:0] r_resData;
   logic             r_zero;
   logic             r_neg;
   logic             r_carry;
   logic             r_ovf;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_carry;
   logic             w_ovf;
   logic             w_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (req_valid) w_nextState = ISSUE;
         ISSUE:   w_nextState = HOLD;
         HOLD:    if (res_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      res_valid = 1'b0;
      case (r_state)
         IDLE:    req_ready = 1'b1;
         HOLD:    res_valid = 1'b1;
         default: ;
      endcase
   end

   assign w_accept = (r_state == IDLE) && req_valid;

   // Carry/overflow come from a private WIDTH+1-bit adder on the registered operands,
   // so they stay correct regardless of how the external ALU reports its result.
   always_comb begin
      w_sum   = {1'b0, r_aluA} + {1'b0, r_aluB};
      w_diff  = {1'b0, r_aluA} - {1'b0, r_aluB};
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (r_aluSel)
         SEL_ADD: begin
            w_carry = w_sum[WIDTH];
            w_ovf   = (r_aluA[WIDTH-1] == r_aluB[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_aluA[WIDTH-1]);
         end
         SEL_SUB: begin
            w_carry = w_diff[WIDTH];
            w_ovf   = (r_aluA[WIDTH-1] != r_aluB[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != r_aluA[WIDTH-1]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_aluA    <= '0;
         r_aluB    <= '0;
         r_aluSel  <= '0;
         r_resData <= '0;
         r_zero    <= 1'b0;
         r_neg     <= 1'b0;
         r_carry   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_aluA   <= req_a;
            r_aluB   <= req_b;
            r_aluSel <= req_sel;
         end
         if (r_state == ISSUE) begin
            r_resData <= alu_out;
            r_zero    <= (alu_out == '0);
            r_neg     <= alu_out[WIDTH-1];
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
         end
      end
   end

   assign alu_inputA = r_aluA;
   assign alu_inputB = r_aluB;
   assign alu_sel    = r_aluSel;
   assign res_data   = r_resData;
   assign res_zero   = r_zero;
   assign res_neg    = r_neg;
   assign res_carry  = r_carry;
   assign res_ovf    = r_ovf;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU closing the loop.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic [31:0] data;
      logic        zero;
      logic        neg;
      logic        carry;
      logic        ovf;
   } expT;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [1:0]  req_sel = '0;
   logic [31:0] alu_inputA;
   logic [31:0] alu_inputB;
   logic [1:0]  alu_sel;
   logic [31:0] alu_out;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_zero;
   logic        res_neg;
   logic        res_carry;
   logic        res_ovf;

   int  checkCount = 0;
   int  errorCount = 0;
   int  cycle = 0;
   int  reqCycle = 0;
   expT expQ[$];

   alu_op_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_inputA(alu_inputA), .alu_inputB(alu_inputB), .alu_sel(alu_sel),
      .alu_out(alu_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .res_neg(res_neg), .res_carry(res_carry), .res_ovf(res_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural ALU that the sequencer drives
   always_comb begin
      case (alu_sel)
         2'd0:    alu_out = alu_inputA + alu_inputB;
         2'd1:    alu_out = alu_inputA - alu_inputB;
         2'd2:    alu_out = alu_inputA & alu_inputB;
         default: alu_out = alu_inputA | alu_inputB;
      endcase
   end

   function automatic expT refModel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
      expT r;
      longint unsigned ua, ub;
      longint sa, sb, sr;
      r  = '0;
      ua = 64'(a);
      ub = 64'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (sel)
         2'd0: begin
            r.data  = a + b;
            r.carry = (ua + ub) > 64'hFFFF_FFFF;
            sr      = sa + sb;
            r.ovf   = (sr > SMAX) || (sr < SMIN);
         end
         2'd1: begin
            r.data  = a - b;
            r.carry = ua < ub;
            sr      = sa - sb;
            r.ovf   = (sr > SMAX) || (sr < SMIN);
         end
         2'd2:    r.data = a & b;
         default: r.data = a | b;
      endcase
      r.zero = (r.data == 32'd0);
      r.neg  = r.data[31];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Waits (bounded) for req_ready, presents the request for exactly one accept edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                                input bit push);
      int waitCycles = 0;
      while (!req_ready && waitCycles < 20) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("reqReadyWait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sel   = sel;
      reqCycle  = cycle;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (push) expQ.push_back(refModel(a, b, sel));
   endtask

   // Bounded wait for res_valid, then scoreboard compare; leaves the DUT in HOLD.
   task automatic waitResult(output expT e);
      int waitCycles = 0;
      e = '0;
      while (!res_valid && waitCycles < 10) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("resValidSeen", 32'(res_valid), 32'd1);
      checkOutput("latencyEdges", 32'(cycle - reqCycle), 32'd2);
      if (expQ.size() == 0) begin
         checkOutput("scoreboardEmpty", 32'd0, 32'd1);
      end else begin
         e = expQ.pop_front();
         checkOutput("resData", res_data, e.data);
         checkOutput("resFlags", 32'({res_zero, res_neg, res_carry, res_ovf}),
                     32'({e.zero, e.neg, e.carry, e.ovf}));
      end
   endtask

   task automatic releaseResult();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checkOutput("resValidDrop", 32'(res_valid), 32'd0);
      checkOutput("reqReadyBack", 32'(req_ready), 32'd1);
   endtask

   task automatic runOne(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
      expT e;
      applyStimulus(a, b, sel, 1'b1);
      waitResult(e);
      releaseResult();
   endtask

   logic [31:0] tblA [3];
   logic [31:0] tblB [3];
   logic [1:0]  tblS [3];

   initial begin
      expT e;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstReqReady", 32'(req_ready), 32'd1);
      checkOutput("rstResValid", 32'(res_valid), 32'd0);
      checkOutput("rstAluA", alu_inputA, 32'd0);
      checkOutput("rstAluB", alu_inputB, 32'd0);
      checkOutput("rstAluSel", 32'(alu_sel), 32'd0);
      checkOutput("rstResData", res_data, 32'd0);
      checkOutput("rstFlags", 32'({res_zero, res_neg, res_carry, res_ovf}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int s = 0; s < 4; s++) runOne(32'd5001, 32'd3001, 2'(s));

      runOne(32'd0, 32'd1, 2'd1);
      runOne(32'hFFFF_FFFF, 32'd1, 2'd0);
      runOne(32'h7FFF_FFFF, 32'd1, 2'd0);
      runOne(32'h8000_0000, 32'd1, 2'd1);

      for (int i = 0; i < 4; i++) runOne($urandom, $urandom, 2'($urandom_range(0, 3)));

      // Reset while in ISSUE drops the request
      applyStimulus(32'd77, 32'd88, 2'd0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midRstResValid", 32'(res_valid), 32'd0);
      checkOutput("midRstReqReady", 32'(req_ready), 32'd1);
      checkOutput("midRstAluA", alu_inputA, 32'd0);
      @(posedge clk); #1;
      checkOutput("midRstStillIdle", 32'(res_valid), 32'd0);

      // Backpressure with a competing request during HOLD
      applyStimulus(32'd1234, 32'd4321, 2'd0, 1'b1);
      waitResult(e);
      req_valid = 1'b1;
      req_a     = 32'd111;
      req_b     = 32'd222;
      req_sel   = 2'd1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checkOutput("bpResValid", 32'(res_valid), 32'd1);
         checkOutput("bpResData", res_data, e.data);
         checkOutput("bpReqReady", 32'(req_ready), 32'd0);
         checkOutput("bpAluA", alu_inputA, 32'd1234);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checkOutput("bpRelValid", 32'(res_valid), 32'd0);
      checkOutput("bpRelReady", 32'(req_ready), 32'd1);
      checkOutput("bpRelAluA", alu_inputA, 32'd1234);
      reqCycle = cycle;
      @(posedge clk); #1;
      req_valid = 1'b0;
      expQ.push_back(refModel(32'd111, 32'd222, 2'd1));
      checkOutput("bpNewAluA", alu_inputA, 32'd111);
      checkOutput("bpNewSel", 32'(alu_sel), 32'd1);
      waitResult(e);
      releaseResult();

      // Back-to-back: accepts land every third edge
      tblA[0] = 32'd10;         tblB[0] = 32'd20;  tblS[0] = 2'd0;
      tblA[1] = 32'hF0F0_0000;  tblB[1] = 32'd3;   tblS[1] = 2'd3;
      tblA[2] = 32'd9;          tblB[2] = 32'd12;  tblS[2] = 2'd1;
      res_ready = 1'b1;
      req_valid = 1'b1;
      req_a     = tblA[0];
      req_b     = tblB[0];
      req_sel   = tblS[0];
      for (int k = 0; k < 9; k++) begin
         int idx;
         idx = k / 3;
         @(posedge clk); #1;
         checkOutput("b2bAluA", alu_inputA, tblA[idx]);
         checkOutput("b2bAluSel", 32'(alu_sel), 32'(tblS[idx]));
         checkOutput("b2bReqReady", 32'(req_ready), 32'(k % 3 == 2));
         checkOutput("b2bResValid", 32'(res_valid), 32'(k % 3 == 1));
         if (k % 3 == 0) begin
            expQ.push_back(refModel(tblA[idx], tblB[idx], tblS[idx]));
            if (idx < 2) begin
               req_a   = tblA[idx + 1];
               req_b   = tblB[idx + 1];
               req_sel = tblS[idx + 1];
            end else begin
               req_valid = 1'b0;
            end
         end else if (k % 3 == 1) begin
            if (expQ.size() == 0) begin
               checkOutput("b2bScoreboardEmpty", 32'd0, 32'd1);
            end else begin
               e = expQ.pop_front();
               checkOutput("b2bResData", res_data, e.data);
               checkOutput("b2bFlags", 32'({res_zero, res_neg, res_carry, res_ovf}),
                           32'({e.zero, e.neg, e.carry, e.ovf}));
            end
         end
      end
      res_ready = 1'b0;
      req_valid = 1'b0;
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
